// File: rtl/bool_pkg.sv
// Shared opcode and output-state definitions for the registered boolean unit.
package bool_pkg;

  typedef enum logic [2:0] {
    OP_NOT_A = 3'd0,
    OP_NOT_B = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_NAND  = 3'd4,
    OP_NOR   = 3'd5,
    OP_XOR   = 3'd6,
    OP_XNOR  = 3'd7
  } op_e;

  localparam logic [2:0] OPC_NOT_A = 3'd0;
  localparam logic [2:0] OPC_NOT_B = 3'd1;
  localparam logic [2:0] OPC_AND   = 3'd2;
  localparam logic [2:0] OPC_OR    = 3'd3;
  localparam logic [2:0] OPC_NAND  = 3'd4;
  localparam logic [2:0] OPC_NOR   = 3'd5;
  localparam logic [2:0] OPC_XOR   = 3'd6;
  localparam logic [2:0] OPC_XNOR  = 3'd7;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } ostate_e;

endpackage

// File: rtl/bool_op_core.sv
// Combinational bitwise operator: applies one of eight boolean functions to a and b.
module bool_op_core
  import bool_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_NOT_A: result = ~a;
      OP_NOT_B: result = ~b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_NAND:  result = ~(a & b);
      OP_NOR:   result = ~(a | b);
      OP_XOR:   result = a ^ b;
      OP_XNOR:  result = ~(a ^ b);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/bool_unit.sv
// Registered boolean unit with valid/ready handshake, chaining accumulator,
// registered reduction flags and a saturating accepted-beat counter.
module bool_unit
  import bool_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b0}},
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor,
  output logic             zero,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] beat_cnt
);

  ostate_e          r_state;
  ostate_e          w_state_nxt;
  logic [WIDTH-1:0] r_y;
  logic             r_red_and;
  logic             r_red_or;
  logic             r_red_xor;
  logic             r_zero;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_out_valid;
  logic             w_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_b_src;
  logic [WIDTH-1:0] w_result;

  assign w_out_valid = (r_state == S_FULL);
  assign in_ready    = !w_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_xfer      = w_out_valid && out_ready;

  // A clear on the same beat as accumulation starts the chain from ACC_INIT.
  assign w_b_src = acc_en ? (acc_clr ? ACC_INIT : r_acc) : b;

  bool_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (a),
    .b      (w_b_src),
    .op     (op),
    .result (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL:  if (w_xfer && !w_accept) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_red_and <= 1'b0;
      r_red_or  <= 1'b0;
      r_red_xor <= 1'b0;
      r_zero    <= 1'b1;
    end else if (w_accept) begin
      r_y       <= w_result;
      r_red_and <= &w_result;
      r_red_or  <= |w_result;
      r_red_xor <= ^w_result;
      r_zero    <= (w_result == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= ACC_INIT;
    end else if (w_accept && acc_en) begin
      r_acc <= w_result;
    end else if (acc_clr) begin
      r_acc <= ACC_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = w_out_valid;
  assign y         = r_y;
  assign red_and   = r_red_and;
  assign red_or    = r_red_or;
  assign red_xor   = r_red_xor;
  assign zero      = r_zero;
  assign acc       = r_acc;
  assign beat_cnt  = r_cnt;

endmodule

// File: tb/tb_bool_unit.sv
// Directed bench for bool_unit: a reference model checked every cycle plus literal expectations.
module tb_bool_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [2:0]  op = '0;
  logic        acc_en = 1'b0;
  logic        acc_clr = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, red_and, red_or, red_xor, zero;
  logic [7:0]  y, acc;
  logic [15:0] beat_cnt;

  logic        in_ready2, out_valid2, red_and2, red_or2, red_xor2, zero2;
  logic [7:0]  y2, acc2;
  logic [1:0]  beat_cnt2;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bool_unit #(.WIDTH(8), .ACC_INIT(8'h00), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .red_and(red_and), .red_or(red_or), .red_xor(red_xor), .zero(zero),
    .acc(acc), .beat_cnt(beat_cnt)
  );

  bool_unit #(.WIDTH(8), .ACC_INIT(8'h00), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid2), .out_ready(out_ready), .y(y2),
    .red_and(red_and2), .red_or(red_or2), .red_xor(red_xor2), .zero(zero2),
    .acc(acc2), .beat_cnt(beat_cnt2)
  );

  // Reference model: state of the unit as the behavioural rules describe it.
  logic [7:0] m_y = '0;
  logic       m_valid = 1'b0;
  logic [7:0] m_acc = '0;
  int         m_cnt = 0;
  int         m_cnt2 = 0;

  function automatic logic [7:0] f_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0:    return ~x;
      3'd1:    return ~z;
      3'd2:    return x & z;
      3'd3:    return x | z;
      3'd4:    return ~(x & z);
      3'd5:    return ~(x | z);
      3'd6:    return x ^ z;
      default: return ~(x ^ z);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] bsrc, res;
    if (!rst_n) begin
      m_y <= '0; m_valid <= 1'b0; m_acc <= 8'h00; m_cnt <= 0; m_cnt2 <= 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      bsrc = acc_en ? (acc_clr ? 8'h00 : m_acc) : b;
      res  = f_op(op, a, bsrc);
      m_y <= res;
      m_valid <= 1'b1;
      if (m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (m_cnt2 < 3) m_cnt2 <= m_cnt2 + 1;
      if (acc_en) m_acc <= res;
      else if (acc_clr) m_acc <= 8'h00;
    end else begin
      if (m_valid && out_ready) m_valid <= 1'b0;
      if (acc_clr) m_acc <= 8'h00;
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("y", 32'(y), 32'(m_y));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      check("red_and", 32'(red_and), 32'(&m_y));
      check("red_or", 32'(red_or), 32'(|m_y));
      check("red_xor", 32'(red_xor), 32'(^m_y));
      check("zero", 32'(zero), 32'(m_y == 8'h00));
      check("acc", 32'(acc), 32'(m_acc));
      check("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
      check("beat_cnt2", 32'(beat_cnt2), 32'(m_cnt2));
      check("y2", 32'(y2), 32'(m_y));
    end
  end

  task automatic send(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic ae, input logic ac);
    @(negedge clk); #1;
    op = o; a = av; b = bv; acc_en = ae; acc_clr = ac; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
  endtask

  logic [7:0] exp_t1 [8] = '{8'h5A, 8'hF0, 8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55};
  logic [1:0] exp_c2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;

    // Sweep of all opcodes; the narrow counter saturates along the way.
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 8'hA5, 8'h0F, 1'b0, 1'b0);
      check($sformatf("t1_y_op%0d", i), 32'(y), 32'(exp_t1[i]));
      if (i < 5) check($sformatf("t6_cnt2_%0d", i), 32'(beat_cnt2), 32'(exp_c2[i]));
    end
    check("t1_beat_cnt", 32'(beat_cnt), 32'd8);

    send(3'd4, 8'hFF, 8'hFF, 1'b0, 1'b0);
    check("t2_nand_y", 32'(y), 32'h00);
    check("t2_nand_zero", 32'(zero), 32'd1);
    check("t2_nand_or", 32'(red_or), 32'd0);
    check("t2_nand_xor", 32'(red_xor), 32'd0);
    send(3'd3, 8'h01, 8'h00, 1'b0, 1'b0);
    check("t2_or_y", 32'(y), 32'h01);
    check("t2_or_zero", 32'(zero), 32'd0);
    check("t2_or_xor", 32'(red_xor), 32'd1);
    check("t2_or_and", 32'(red_and), 32'd0);

    // Backpressure: result held, next beat waits, then loads with the transfer.
    send(3'd2, 8'h3C, 8'hF0, 1'b0, 1'b0);
    out_ready = 1'b0;
    op = 3'd6; a = 8'h3C; b = 8'hF0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_stall_y", 32'(y), 32'h30);
      check("t3_stall_in_ready", 32'(in_ready), 32'd0);
      check("t3_stall_valid", 32'(out_valid), 32'd1);
    end
    #1 out_ready = 1'b1;
    #1 check("t3_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t3_next_y", 32'(y), 32'hCC);
    check("t3_next_valid", 32'(out_valid), 32'd1);

    // Accumulate chain, cleared on the first beat.
    send(3'd3, 8'h80, 8'h00, 1'b1, 1'b0);
    check("t4_pre_acc", 32'(acc), 32'h80);
    send(3'd6, 8'h01, 8'hFF, 1'b1, 1'b1);
    check("t4_y1", 32'(y), 32'h01);
    send(3'd6, 8'h02, 8'hFF, 1'b1, 1'b0);
    check("t4_y2", 32'(y), 32'h03);
    send(3'd6, 8'h04, 8'hFF, 1'b1, 1'b0);
    check("t4_y3", 32'(y), 32'h07);
    send(3'd6, 8'h08, 8'hFF, 1'b1, 1'b0);
    check("t4_y4", 32'(y), 32'h0F);
    check("t4_acc", 32'(acc), 32'h0F);

    // Asynchronous reset in the middle of a stall.
    send(3'd2, 8'hFF, 8'h0F, 1'b0, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    check("t5_stalled", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_acc", 32'(acc), 32'h00);
    check("t5_cnt", 32'(beat_cnt), 32'd0);
    check("t5_y", 32'(y), 32'h00);
    check("t5_zero", 32'(zero), 32'd1);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("post_y", 32'(y), 32'hFF);
    check("post_and", 32'(red_and), 32'd1);
    check("post_cnt", 32'(beat_cnt), 32'd1);

    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
